// File: rtl/weather_frame_tx.sv
// Serial transmitter for the weather-sensor link: captures temperature, humidity and wind
// codes and shifts them out MSB first as TEMP,SEP0,HUM,SEP1,WIND,SEP2 on the one-bit line x.
module weather_frame_tx #(
  parameter int   CODE_W     = 3,
  parameter int   SEP_W      = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic [CODE_W-1:0] temp,
  input  logic [CODE_W-1:0] hum,
  input  logic [CODE_W-1:0] wind,
  output logic              ready,
  output logic              x,
  output logic              bit_valid,
  output logic              frame_done
);

  localparam int MAX_W = (CODE_W > SEP_W) ? CODE_W : SEP_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [CNT_W-1:0] CODE_LAST = CNT_W'(CODE_W - 1);
  localparam logic [CNT_W-1:0] SEP_LAST  = CNT_W'(SEP_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Separator n carries the field index n, truncated to the separator width.
  localparam logic [SEP_W-1:0] SEP0_VAL = SEP_W'(0);
  localparam logic [SEP_W-1:0] SEP1_VAL = SEP_W'(1);
  localparam logic [SEP_W-1:0] SEP2_VAL = SEP_W'(2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TEMP = 3'd1,
    S_SEP0 = 3'd2,
    S_HUM  = 3'd3,
    S_SEP1 = 3'd4,
    S_WIND = 3'd5,
    S_SEP2 = 3'd6
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CODE_W-1:0] r_temp;
  logic [CODE_W-1:0] r_hum;
  logic [CODE_W-1:0] r_wind;
  logic              r_ready;
  logic              r_x;
  logic              r_bit_valid;
  logic              r_frame_done;

  state_t            w_state_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic              w_accept;
  logic              w_field_end;
  logic [CODE_W-1:0] w_temp_nx;
  logic [CODE_W-1:0] w_hum_nx;
  logic [CODE_W-1:0] w_wind_nx;
  logic [CODE_W-1:0] w_temp_sh;
  logic [CODE_W-1:0] w_hum_sh;
  logic [CODE_W-1:0] w_wind_sh;
  logic [SEP_W-1:0]  w_sep0_sh;
  logic [SEP_W-1:0]  w_sep1_sh;
  logic [SEP_W-1:0]  w_sep2_sh;
  logic              w_x_nx;
  logic              w_bit_valid_nx;
  logic              w_frame_done_nx;
  logic              w_ready_nx;

  assign w_accept    = start & r_ready;
  assign w_field_end = (r_cnt == CNT_ZERO);

  // Codes are latched only on acceptance, so later input changes cannot disturb the frame.
  assign w_temp_nx = w_accept ? temp : r_temp;
  assign w_hum_nx  = w_accept ? hum  : r_hum;
  assign w_wind_nx = w_accept ? wind : r_wind;

  assign w_temp_sh = w_temp_nx >> w_cnt_nx;
  assign w_hum_sh  = w_hum_nx  >> w_cnt_nx;
  assign w_wind_sh = w_wind_nx >> w_cnt_nx;
  assign w_sep0_sh = SEP0_VAL  >> w_cnt_nx;
  assign w_sep1_sh = SEP1_VAL  >> w_cnt_nx;
  assign w_sep2_sh = SEP2_VAL  >> w_cnt_nx;

  // Next state and per-field bit counter.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt - CNT_ONE;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx = S_TEMP;
          w_cnt_nx   = CODE_LAST;
        end else begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = CNT_ZERO;
        end
      end
      S_TEMP: begin
        if (w_field_end) begin
          w_state_nx = S_SEP0;
          w_cnt_nx   = SEP_LAST;
        end else begin
          w_cnt_nx   = r_cnt - CNT_ONE;
        end
      end
      S_SEP0: begin
        if (w_field_end) begin
          w_state_nx = S_HUM;
          w_cnt_nx   = CODE_LAST;
        end else begin
          w_cnt_nx   = r_cnt - CNT_ONE;
        end
      end
      S_HUM: begin
        if (w_field_end) begin
          w_state_nx = S_SEP1;
          w_cnt_nx   = SEP_LAST;
        end else begin
          w_cnt_nx   = r_cnt - CNT_ONE;
        end
      end
      S_SEP1: begin
        if (w_field_end) begin
          w_state_nx = S_WIND;
          w_cnt_nx   = CODE_LAST;
        end else begin
          w_cnt_nx   = r_cnt - CNT_ONE;
        end
      end
      S_WIND: begin
        if (w_field_end) begin
          w_state_nx = S_SEP2;
          w_cnt_nx   = SEP_LAST;
        end else begin
          w_cnt_nx   = r_cnt - CNT_ONE;
        end
      end
      S_SEP2: begin
        // A start taken on the last separator bit chains straight into the next TEMP field.
        if (w_field_end && w_accept) begin
          w_state_nx = S_TEMP;
          w_cnt_nx   = CODE_LAST;
        end else if (w_field_end) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = CNT_ZERO;
        end else begin
          w_cnt_nx   = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = CNT_ZERO;
      end
    endcase
  end

  // Output values for the coming cycle, derived from where the FSM is headed.
  always_comb begin
    w_x_nx = IDLE_LEVEL;
    case (w_state_nx)
      S_IDLE:  w_x_nx = IDLE_LEVEL;
      S_TEMP:  w_x_nx = w_temp_sh[0];
      S_SEP0:  w_x_nx = w_sep0_sh[0];
      S_HUM:   w_x_nx = w_hum_sh[0];
      S_SEP1:  w_x_nx = w_sep1_sh[0];
      S_WIND:  w_x_nx = w_wind_sh[0];
      S_SEP2:  w_x_nx = w_sep2_sh[0];
      default: w_x_nx = IDLE_LEVEL;
    endcase
    w_bit_valid_nx  = (w_state_nx != S_IDLE);
    w_frame_done_nx = (w_state_nx == S_SEP2) && (w_cnt_nx == CNT_ZERO);
    w_ready_nx      = (w_state_nx == S_IDLE) || w_frame_done_nx;
  end

  // State, capture and output registers; reset abandons any frame in flight.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= CNT_ZERO;
      r_temp       <= {CODE_W{1'b0}};
      r_hum        <= {CODE_W{1'b0}};
      r_wind       <= {CODE_W{1'b0}};
      r_x          <= IDLE_LEVEL;
      r_bit_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_temp       <= w_temp_nx;
      r_hum        <= w_hum_nx;
      r_wind       <= w_wind_nx;
      r_x          <= w_x_nx;
      r_bit_valid  <= w_bit_valid_nx;
      r_frame_done <= w_frame_done_nx;
      r_ready      <= w_ready_nx;
    end
  end

  assign ready      = r_ready;
  assign x          = r_x;
  assign bit_valid  = r_bit_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_weather_frame_tx.sv
// Directed bench for weather_frame_tx: expected {x,bit_valid,frame_done,ready} per cycle is
// queued as stimulus is driven and compared one cycle later, 1 time unit after the edge.
module tb_weather_frame_tx;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       start;
  logic [2:0] temp;
  logic [2:0] hum;
  logic [2:0] wind;
  logic       ready;
  logic       x;
  logic       bit_valid;
  logic       frame_done;

  logic [3:0] exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [14:0] f;

  localparam logic [3:0] IDLE_EXP = 4'b0001;

  weather_frame_tx dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .start      (start),
    .temp       (temp),
    .hum        (hum),
    .wind       (wind),
    .ready      (ready),
    .x          (x),
    .bit_valid  (bit_valid),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [14:0] mk(input logic [2:0] t, input logic [2:0] h, input logic [2:0] w);
    return {t, 2'b00, h, 2'b01, w, 2'b10};
  endfunction

  function automatic logic [3:0] fexp(input logic [14:0] fr, input int i);
    logic last;
    last = (i == 14);
    return {fr[14-i], 1'b1, last, last};
  endfunction

  task automatic tick(input logic [3:0] e, input string tag);
    logic [3:0] exp_v;
    logic [3:0] obs;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    exp_v = exp_q.pop_front();
    obs   = {x, bit_valid, frame_done, ready};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s obs{x,bv,fd,rdy}=%b exp=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    Reset = 1'b0; start = 1'b0; temp = 3'b000; hum = 3'b000; wind = 3'b000;

    // 1: reset for two edges, then idle
    tick(IDLE_EXP, "reset0");
    tick(IDLE_EXP, "reset1");
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) tick(IDLE_EXP, "idle_after_reset");

    // 2: single frame 111/010/101, then line returns to idle
    f = mk(3'b111, 3'b010, 3'b101);
    start = 1'b1; temp = 3'b111; hum = 3'b010; wind = 3'b101;
    tick(fexp(f, 0), "frameA");
    start = 1'b0;
    for (int i = 1; i < 15; i++) tick(fexp(f, i), "frameA");
    tick(IDLE_EXP, "frameA_idle");

    // 3: same frame again, chained gaplessly into 000/111/011 on frame_done
    start = 1'b1;
    tick(fexp(f, 0), "frameC");
    start = 1'b0;
    for (int i = 1; i < 15; i++) tick(fexp(f, i), "frameC");
    f = mk(3'b000, 3'b111, 3'b011);
    start = 1'b1; temp = 3'b000; hum = 3'b111; wind = 3'b011;
    tick(fexp(f, 0), "frameB_chain");

    // 4: start pulses while busy and mid-frame code changes are ignored
    for (int i = 1; i < 15; i++) begin
      start = (i == 4) || (i == 9);
      if (i == 4) begin
        temp = 3'b101; hum = 3'b001; wind = 3'b110;
      end else begin
        temp = temp;
      end
      tick(fexp(f, i), "frameB_busy_start");
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick(IDLE_EXP, "no_queued_frame");

    // 5: reset during HUM bit 2 abandons the frame; a fresh frame follows
    f = mk(3'b101, 3'b110, 3'b011);
    start = 1'b1; temp = 3'b101; hum = 3'b110; wind = 3'b011;
    tick(fexp(f, 0), "frameR");
    start = 1'b0;
    for (int i = 1; i < 6; i++) tick(fexp(f, i), "frameR");
    Reset = 1'b0;
    tick(IDLE_EXP, "midframe_reset");
    Reset = 1'b1;
    tick(IDLE_EXP, "after_midframe_reset");
    f = mk(3'b011, 3'b100, 3'b110);
    start = 1'b1; temp = 3'b011; hum = 3'b100; wind = 3'b110;
    tick(fexp(f, 0), "frameF");
    start = 1'b0;
    for (int i = 1; i < 15; i++) tick(fexp(f, i), "frameF");
    tick(IDLE_EXP, "frameF_idle");

    // 6: start coincident with reset: reset wins
    start = 1'b1; Reset = 1'b0; temp = 3'b111; hum = 3'b111; wind = 3'b111;
    tick(IDLE_EXP, "start_with_reset");
    start = 1'b0; Reset = 1'b1;
    tick(IDLE_EXP, "post_start_reset0");
    tick(IDLE_EXP, "post_start_reset1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
